// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle ARM-subset controller: FSM state
// encoding, ALU operation codes, instruction field constants, flag layout.
package multicycle_controller_pkg;

    // Default width of the ALUControl output (2 = ADD/SUB/AND/ORR, 3 adds EOR)
    localparam int ALUCTRL_W_DEFAULT = 2;

    // One state per instruction phase
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    // ALU operation encodings as seen on ALUControl
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    // Op field values
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing command field values (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Architectural flags, same bit order as the ALUFlags input {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Logical operations only ever update N and Z
    function automatic logic alu_is_logical(input logic [2:0] alu_op);
        logic is_logical;
        case (alu_op)
            ALU_AND: is_logical = 1'b1;
            ALU_ORR: is_logical = 1'b1;
            ALU_EOR: is_logical = 1'b1;
            default: is_logical = 1'b0;
        endcase
        return is_logical;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational condition-code evaluator: decides whether an instruction with
// the given Cond field executes against the current flags.
module multicycle_controller_cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    // Evaluate the condition field against N, Z, C, V
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = flags.z;
            COND_NE: cond_ex = ~flags.z;
            COND_CS: cond_ex = flags.c;
            COND_CC: cond_ex = ~flags.c;
            COND_MI: cond_ex = flags.n;
            COND_PL: cond_ex = ~flags.n;
            COND_VS: cond_ex = flags.v;
            COND_VC: cond_ex = ~flags.v;
            COND_HI: cond_ex = flags.c & ~flags.z;
            COND_LS: cond_ex = ~flags.c | flags.z;
            COND_GE: cond_ex = (flags.n == flags.v);
            COND_LT: cond_ex = (flags.n != flags.v);
            COND_GT: cond_ex = ~flags.z & (flags.n == flags.v);
            COND_LE: cond_ex = flags.z | (flags.n != flags.v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: Moore FSM sequencing each instruction over
// 3-5 cycles, holding NZCV and gating architectural writes on the condition.
// Optional feature macro: MC_CMP_EN (command 1010 decodes as a compare).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALUCTRL_W = ALUCTRL_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite
);

    // Instruction fields (Instr holds bits [31:12] of the instruction)
    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] rd_s;
    logic [3:0] cmd_s;
    logic       instr_unused_s;

    assign cond_s         = Instr[19:16];
    assign op_s           = Instr[15:14];
    assign funct_s        = Instr[13:8];
    assign rd_s           = Instr[3:0];
    assign cmd_s          = funct_s[4:1];
    assign instr_unused_s = ^Instr[7:4];

    // State and architectural registers
    state_e state_q, state_d;
    flags_t flags_q, flags_d;
    logic   cond_ex_q, cond_ex_d;
    logic   cond_ex_s;

    // Command decode results
    logic [2:0] alu_op_s;
    logic       cmd_defined_s;
    logic       cmd_writes_s;

    // Raw FSM outputs before reset gating
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic [1:0] result_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_sel_s;
    logic       reg_write_s;

    multicycle_controller_cond_check u_cond_check (
        .cond    (cond_s),
        .flags   (flags_q),
        .cond_ex (cond_ex_s)
    );

    // Decode the data-processing command into an ALU operation; undefined
    // commands fall back to ADD and are barred from any architectural write
    always_comb begin
        alu_op_s      = ALU_ADD;
        cmd_defined_s = 1'b0;
        cmd_writes_s  = 1'b0;
        case (cmd_s)
            CMD_ADD: begin
                alu_op_s      = ALU_ADD;
                cmd_defined_s = 1'b1;
                cmd_writes_s  = 1'b1;
            end
            CMD_SUB: begin
                alu_op_s      = ALU_SUB;
                cmd_defined_s = 1'b1;
                cmd_writes_s  = 1'b1;
            end
            CMD_AND: begin
                alu_op_s      = ALU_AND;
                cmd_defined_s = 1'b1;
                cmd_writes_s  = 1'b1;
            end
            CMD_ORR: begin
                alu_op_s      = ALU_ORR;
                cmd_defined_s = 1'b1;
                cmd_writes_s  = 1'b1;
            end
            CMD_EOR: begin
                if (ALUCTRL_W >= 3) begin
                    alu_op_s      = ALU_EOR;
                    cmd_defined_s = 1'b1;
                    cmd_writes_s  = 1'b1;
                end else begin
                    alu_op_s      = ALU_ADD;
                    cmd_defined_s = 1'b0;
                    cmd_writes_s  = 1'b0;
                end
            end
`ifdef MC_CMP_EN
            CMD_CMP: begin
                // Compare: subtract for flags only, never writes a result
                alu_op_s      = ALU_SUB;
                cmd_defined_s = 1'b1;
                cmd_writes_s  = 1'b0;
            end
`else
`endif
            default: begin
                alu_op_s      = ALU_ADD;
                cmd_defined_s = 1'b0;
                cmd_writes_s  = 1'b0;
            end
        endcase
    end

    // Next-state, Moore outputs and next values of cond_ex/flags
    always_comb begin
        state_d      = state_q;
        cond_ex_d    = cond_ex_q;
        flags_d      = flags_q;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_sel_s    = ALU_ADD;
        reg_write_s  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                pc_write_s   = 1'b1;
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                alu_sel_s    = ALU_ADD;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                alu_sel_s    = ALU_ADD;
                // Condition is frozen here so EXEC flag updates cannot
                // influence this instruction's own writeback
                cond_ex_d    = cond_ex_s;
                case (op_s)
                    OP_MEM: state_d = S_MEMADR;
                    OP_DP: begin
                        if (funct_s[5]) begin
                            state_d = S_EXECI;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    OP_BR:  state_d = S_BRANCH;
                    OP_NOP: state_d = S_FETCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b_s = 2'b01;
                alu_sel_s   = ALU_ADD;
                if (funct_s[0]) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                adr_src_s = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = cond_ex_q;
                pc_write_s   = (rd_s == 4'd15) & cond_ex_q;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                adr_src_s   = 1'b1;
                mem_write_s = cond_ex_q;
                state_d     = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                if (state_q == S_EXECI) begin
                    alu_src_b_s = 2'b01;
                end else begin
                    alu_src_b_s = 2'b00;
                end
                alu_sel_s = alu_op_s;
                if (funct_s[0] && cond_ex_q && cmd_defined_s) begin
                    flags_d.n = ALUFlags[3];
                    flags_d.z = ALUFlags[2];
                    if (alu_is_logical(alu_op_s)) begin
                        flags_d.c = flags_q.c;
                        flags_d.v = flags_q.v;
                    end else begin
                        flags_d.c = ALUFlags[1];
                        flags_d.v = ALUFlags[0];
                    end
                end else begin
                    flags_d = flags_q;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = cond_ex_q & cmd_writes_s;
                pc_write_s  = (rd_s == 4'd15) & cond_ex_q & cmd_writes_s;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                alu_sel_s    = ALU_ADD;
                pc_write_s   = cond_ex_q;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output stage: while in reset, suppress all writes and show FETCH selects
    always_comb begin
        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b10;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALUCTRL_W'(ALU_ADD);
            RegWrite   = 1'b0;
        end else begin
            PCWrite    = pc_write_s;
            AdrSrc     = adr_src_s;
            MemWrite   = mem_write_s;
            IRWrite    = ir_write_s;
            ResultSrc  = result_src_s;
            ALUSrcA    = alu_src_a_s;
            ALUSrcB    = alu_src_b_s;
            ALUControl = ALUCTRL_W'(alu_sel_s);
            RegWrite   = reg_write_s;
        end
    end

    // Immediate and register-source selects depend only on the instruction
    always_comb begin
        ImmSrc = op_s;
        RegSrc = {(op_s == OP_MEM), (op_s == OP_BR)};
    end

    // State, flags and registered condition with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= flags_t'(4'b0000);
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: two controllers (ALUCTRL_W=2 and 3) share stimulus and
// are compared every cycle against an instruction-level reference model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;

    logic       a_pcw, a_adr, a_memw, a_irw, a_srca, a_regw;
    logic [1:0] a_res, a_srcb, a_imm, a_rsrc, a_alu;
    logic       b_pcw, b_adr, b_memw, b_irw, b_srca, b_regw;
    logic [1:0] b_res, b_srcb, b_imm, b_rsrc;
    logic [2:0] b_alu;

    int total = 0;
    int bad   = 0;
    int force_flags = -1;

    // Reference model state, index 0 = width 2, index 1 = width 3
    logic [3:0] m_flags [2];
    logic       m_cond  [2];

    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4;
    localparam int PH_MW = 5, PH_XR = 6, PH_XI = 7, PH_AW = 8, PH_BR = 9, PH_RST = 10;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUCTRL_W(2)) dut_a (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_memw), .IRWrite(a_irw),
        .ResultSrc(a_res), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ImmSrc(a_imm),
        .RegSrc(a_rsrc), .ALUControl(a_alu), .RegWrite(a_regw)
    );

    multicycle_controller #(.ALUCTRL_W(3)) dut_b (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_memw), .IRWrite(b_irw),
        .ResultSrc(b_res), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ImmSrc(b_imm),
        .RegSrc(b_rsrc), .ALUControl(b_alu), .RegWrite(b_regw)
    );

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h2, rd};
    endfunction

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // -1 undefined; 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 CMP
    function automatic int cmd_kind(input logic [3:0] cmd, input int w);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return (w >= 3) ? 4 : -1;
`ifdef MC_CMP_EN
            4'b1010: return 5;
`endif
            default: return -1;
        endcase
    endfunction

    // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
    //           ImmSrc,RegSrc,ALUControl(3b),RegWrite} for one cycle
    function automatic logic [16:0] expect_vec(input int w, input int ph,
                                               input logic [19:0] ins, input logic cnd);
        logic pcw, adr, memw, irw, srca, regw;
        logic [1:0] res, srcb, op;
        logic [2:0] alu;
        logic [5:0] f;
        int k;
        op = ins[15:14];
        f  = ins[13:8];
        k  = cmd_kind(f[4:1], w);
        pcw = 0; adr = 0; memw = 0; irw = 0; srca = 0; regw = 0;
        res = 2'd0; srcb = 2'd0; alu = 3'd0;
        if (ph == PH_F) begin
            pcw = 1; irw = 1; srca = 1; srcb = 2'd2; res = 2'd2;
        end else if (ph == PH_D || ph == PH_RST) begin
            srca = 1; srcb = 2'd2; res = 2'd2;
        end else if (ph == PH_MA) begin
            srcb = 2'd1;
        end else if (ph == PH_MR) begin
            adr = 1;
        end else if (ph == PH_MW) begin
            adr = 1; memw = cnd;
        end else if (ph == PH_MWB) begin
            res = 2'd1; regw = cnd; pcw = cnd && (ins[3:0] == 4'd15);
        end else if (ph == PH_XR || ph == PH_XI) begin
            srcb = (ph == PH_XI) ? 2'd1 : 2'd0;
            alu  = (k < 0) ? 3'd0 : ((k == 5) ? 3'd1 : 3'(k));
        end else if (ph == PH_AW) begin
            regw = cnd && k >= 0 && k != 5;
            pcw  = regw && (ins[3:0] == 4'd15);
        end else if (ph == PH_BR) begin
            srcb = 2'd1; res = 2'd2; pcw = cnd;
        end
        return {pcw, adr, memw, irw, res, srca, srcb, op,
                (op == 2'b01), (op == 2'b10), alu, regw};
    endfunction

    task automatic check(input string tag, input int w, input logic [16:0] got,
                         input logic [16:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s w=%0d observed=%05h expected=%05h", tag, w, got, exp);
        end
    endtask

    // One clock cycle: compare both DUTs mid-cycle, then advance the model
    task automatic step(input int ph, input string tag);
        int k;
        ALUFlags = (force_flags >= 0) ? 4'(force_flags) : 4'($urandom);
        @(negedge clk);
        check(tag, 2, {a_pcw, a_adr, a_memw, a_irw, a_res, a_srca, a_srcb, a_imm,
                       a_rsrc, 1'b0, a_alu, a_regw}, expect_vec(2, ph, Instr, m_cond[0]));
        check(tag, 3, {b_pcw, b_adr, b_memw, b_irw, b_res, b_srca, b_srcb, b_imm,
                       b_rsrc, b_alu, b_regw}, expect_vec(3, ph, Instr, m_cond[1]));
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            if (ph == PH_RST) begin
                m_flags[w] = 4'b0000;
                m_cond[w]  = 1'b0;
            end else if (ph == PH_D) begin
                m_cond[w] = cond_holds(Instr[19:16], m_flags[w]);
            end else if (ph == PH_XR || ph == PH_XI) begin
                k = cmd_kind(Instr[12:9], w + 2);
                if (Instr[8] && m_cond[w] && k >= 0) begin
                    if (k == 0 || k == 1 || k == 5) m_flags[w] = ALUFlags;
                    else m_flags[w][3:2] = ALUFlags[3:2];
                end
            end
        end
        #1;
    endtask

    task automatic run_instr(input logic [19:0] ins, input string tag);
        Instr = ins;
        step(PH_F, tag);
        step(PH_D, tag);
        case (ins[15:14])
            2'b01: begin
                step(PH_MA, tag);
                if (ins[8]) begin
                    step(PH_MR, tag);
                    step(PH_MWB, tag);
                end else begin
                    step(PH_MW, tag);
                end
            end
            2'b00: begin
                step(ins[13] ? PH_XI : PH_XR, tag);
                step(PH_AW, tag);
            end
            2'b10: step(PH_BR, tag);
            default: ;
        endcase
    endtask

    initial begin
        logic [3:0] c, rd;
        logic [1:0] op;
        logic [5:0] f;
        m_flags[0] = 4'b0000; m_flags[1] = 4'b0000;
        m_cond[0]  = 1'b0;    m_cond[1]  = 1'b0;
        reset = 1'b1;
        Instr = 20'h00000;
        ALUFlags = 4'b0000;
        step(PH_RST, "reset");
        step(PH_RST, "reset");
        reset = 1'b0;

        // Basic sequences
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'h1), "add_reg");
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'h3), "ldr");
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'h3), "str");
        run_instr(mk(4'hE, 2'b00, 6'b101000, 4'h4), "add_imm");

        // SUBS sets Z, then BEQ taken and BNE not taken
        force_flags = 4'b0100;
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'h1), "subs");
        force_flags = -1;
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), "beq_taken");
        run_instr(mk(4'h1, 2'b10, 6'b000000, 4'h0), "bne_not");

        // Clear Z, then ADDEQ blocked and ADDSEQ leaves flags alone
        force_flags = 4'b0000;
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'h1), "adds_clr");
        force_flags = 4'b1111;
        run_instr(mk(4'h0, 2'b00, 6'b001000, 4'h1), "addeq_blocked");
        run_instr(mk(4'h0, 2'b00, 6'b001001, 4'h1), "addseq_blocked");
        force_flags = -1;
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), "beq_after_blocked");

        // Undefined-at-width-2 EORS, N/Z only at width 3
        force_flags = 4'b0000;
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'h1), "adds_zero");
        force_flags = 4'b1111;
        run_instr(mk(4'hE, 2'b00, 6'b000011, 4'h1), "eors");
        force_flags = -1;
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), "beq_after_eor");
        run_instr(mk(4'h2, 2'b10, 6'b000000, 4'h0), "bcs_after_eor");
        run_instr(mk(4'hE, 2'b11, 6'b111111, 4'hF), "op11");
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'hF), "ldr_pc");

        // Reset in MEMADR of STR after setting Z
        force_flags = 4'b0100;
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'h1), "adds_setz");
        force_flags = -1;
        Instr = mk(4'hE, 2'b01, 6'b011000, 4'h3);
        step(PH_F, "str_rst");
        step(PH_D, "str_rst");
        reset = 1'b1;
        step(PH_RST, "mid_reset");
        step(PH_RST, "mid_reset");
        reset = 1'b0;
        run_instr(mk(4'h0, 2'b10, 6'b000000, 4'h0), "beq_post_reset");
        run_instr(mk(4'h1, 2'b10, 6'b000000, 4'h0), "bne_post_reset");

        // Randomised instruction stream
        for (int i = 0; i < 300; i++) begin
            c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            op = 2'($urandom);
            f  = 6'($urandom);
            rd = 4'($urandom);
            if (op == 2'b00 && rd == 4'hF) f[4:1] = 4'b0100;
            run_instr(mk(c, op, f, rd), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
